// File: rtl/alu_cond_pipe_if.sv
// Handshake and operand/result bundle for alu_cond_pipe.
// slave: the ALU stage itself; master: the upstream/downstream side driving it.
interface alu_cond_pipe_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode_in;
  logic [3:0]   cond_in;
  logic         s_in;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         shifter_carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] alu_out;
  logic         out_executed;
  logic         out_wr_en;

  modport slave (
    input  in_valid, opcode_in, cond_in, s_in, a_in, b_in, shifter_carry_in, out_ready,
    output in_ready, out_valid, alu_out, out_executed, out_wr_en
  );

  modport master (
    output in_valid, opcode_in, cond_in, s_in, a_in, b_in, shifter_carry_in, out_ready,
    input  in_ready, out_valid, alu_out, out_executed, out_wr_en
  );
endinterface

// File: rtl/alu_cond_pipe.sv
// Registered data-processing ALU with condition evaluation and the NZCV flag register.
// flags_out layout: [3]=V [2]=C [1]=Z [0]=N.
// Optional macro ALU_STICKY_Q_EN adds a sticky overflow bit (q_flag_out, cleared by q_clear).
module alu_cond_pipe #(
  parameter int unsigned N = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cond_pipe_if.slave     bus,
  input  logic               flags_wr_in,
  input  logic [3:0]         flags_in,
`ifdef ALU_STICKY_Q_EN
  input  logic               q_clear,
  output logic               q_flag_out,
`endif
  output logic [3:0]         flags_out
);

  logic [3:0]   flags_q;
  logic         out_valid_q;
  logic [N-1:0] alu_out_q;
  logic         executed_q;
  logic         wr_en_q;

  logic flag_v, flag_c, flag_z, flag_n;
  assign {flag_v, flag_c, flag_z, flag_n} = flags_q;

  logic accept;
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Condition check against the flags as they stand before this op.
  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (bus.cond_in)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Adder operand selection; subtracts are x + ~y + cin so sum[N] is NOT borrow.
  logic [N-1:0] add_x, add_y;
  logic         add_cin;
  logic         is_arith;
  always_comb begin
    add_x    = bus.a_in;
    add_y    = bus.b_in;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    case (bus.opcode_in)
      4'b0010, 4'b1010: begin add_y = ~bus.b_in; add_cin = 1'b1; is_arith = 1'b1; end
      4'b0011: begin add_x = bus.b_in; add_y = ~bus.a_in; add_cin = 1'b1; is_arith = 1'b1; end
      4'b0100, 4'b1011: is_arith = 1'b1;
      4'b0101: begin add_cin = flag_c; is_arith = 1'b1; end
      4'b0110: begin add_y = ~bus.b_in; add_cin = flag_c; is_arith = 1'b1; end
      4'b0111: begin add_x = bus.b_in; add_y = ~bus.a_in; add_cin = flag_c; is_arith = 1'b1; end
      default: ;
    endcase
  end

  logic [N:0] sum;
  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{N{1'b0}}, add_cin};

  logic overflow;
  assign overflow = (add_x[N-1] == add_y[N-1]) && (sum[N-1] != add_x[N-1]);

  // Result mux and the flags this op would produce.
  logic [N-1:0] result;
  logic [3:0]   new_flags;
  always_comb begin
    result = sum[N-1:0];
    case (bus.opcode_in)
      4'b0000, 4'b1000: result = bus.a_in & bus.b_in;
      4'b0001, 4'b1001: result = bus.a_in ^ bus.b_in;
      4'b1100:          result = bus.a_in | bus.b_in;
      4'b1101:          result = bus.b_in;
      4'b1110:          result = bus.a_in & ~bus.b_in;
      4'b1111:          result = ~bus.b_in;
      default:          result = sum[N-1:0];
    endcase
    new_flags[0] = result[N-1];
    new_flags[1] = (result == '0);
    new_flags[2] = is_arith ? sum[N] : bus.shifter_carry_in;
    new_flags[3] = is_arith ? overflow : flag_v;
  end

  logic is_cmp, flag_upd;
  assign is_cmp   = (bus.opcode_in[3:2] == 2'b10);
  assign flag_upd = accept && cond_pass && (bus.s_in || is_cmp);

  // Flag register: a direct load beats an ALU update in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (flags_wr_in) begin
      flags_q <= flags_in;
    end else if (flag_upd) begin
      flags_q <= new_flags;
    end
  end

  // Output register: load on acceptance, drop valid on a transfer with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      executed_q  <= 1'b0;
      wr_en_q     <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      alu_out_q   <= cond_pass ? result : '0;
      executed_q  <= cond_pass;
      wr_en_q     <= cond_pass && !is_cmp;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef ALU_STICKY_Q_EN
  logic q_q;
  // Sticky overflow: set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (accept && cond_pass && is_arith && overflow) begin
      q_q <= 1'b1;
    end else if (q_clear) begin
      q_q <= 1'b0;
    end
  end
  assign q_flag_out = q_q;
`endif

  assign bus.out_valid    = out_valid_q;
  assign bus.alu_out      = alu_out_q;
  assign bus.out_executed = executed_q;
  assign bus.out_wr_en    = wr_en_q;
  assign flags_out        = flags_q;

endmodule

// File: tb/tb_alu_cond_pipe.sv
// Directed self-checking bench for alu_cond_pipe (N=32).
module tb_alu_cond_pipe;
  localparam int unsigned N = 32;

  localparam logic [3:0] OpSub = 4'b0010, OpAdd = 4'b0100, OpAdc = 4'b0101, OpSbc = 4'b0110;
  localparam logic [3:0] OpCmp = 4'b1010, OpMov = 4'b1101;
  localparam logic [3:0] CEq = 4'b0000, CNe = 4'b0001, CAl = 4'b1110;

  logic       clk;
  logic       rst_n;
  logic       flags_wr_in;
  logic [3:0] flags_in;
  logic [3:0] flags_out;
`ifdef ALU_STICKY_Q_EN
  logic       q_clear;
  logic       q_flag_out;
`endif

  int passed;
  int total;

  alu_cond_pipe_if #(.N(N)) bus ();

  alu_cond_pipe #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flags_wr_in (flags_wr_in),
    .flags_in    (flags_in),
`ifdef ALU_STICKY_Q_EN
    .q_clear     (q_clear),
    .q_flag_out  (q_flag_out),
`endif
    .flags_out   (flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for exactly one edge; returns 1 time unit after that edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic sc);
    bus.in_valid         = 1'b1;
    bus.opcode_in        = op;
    bus.cond_in          = cond;
    bus.s_in             = s;
    bus.a_in             = a;
    bus.b_in             = b;
    bus.shifter_carry_in = sc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] f);
    flags_wr_in = 1'b1;
    flags_in    = f;
    @(posedge clk);
    #1;
    flags_wr_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.alu_out !== 32'h0) $display("FAIL reset_alu_out got %h want 0", bus.alu_out); else passed++;
    total++; if (flags_out !== 4'b0000) $display("FAIL reset_flags got %b want 0000", flags_out); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_overflow();
    issue(OpAdd, CAl, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.alu_out !== 32'h8000_0000) $display("FAIL add_result got %h want 80000000", bus.alu_out); else passed++;
    total++; if (flags_out !== 4'b1001) $display("FAIL add_flags got %b want 1001", flags_out); else passed++;
    total++; if (bus.out_wr_en !== 1'b1) $display("FAIL add_wr_en got %b want 1", bus.out_wr_en); else passed++;
  endtask

  task automatic test_back_to_back();
    issue(OpCmp, CAl, 1'b0, 32'd5, 32'd5, 1'b0);
    total++; if (flags_out !== 4'b0110) $display("FAIL cmp_flags got %b want 0110", flags_out); else passed++;
    total++; if (bus.out_wr_en !== 1'b0) $display("FAIL cmp_wr_en got %b want 0", bus.out_wr_en); else passed++;
    issue(OpSub, CEq, 1'b0, 32'd9, 32'd4, 1'b0);
    total++; if (bus.out_executed !== 1'b1) $display("FAIL subeq_exec got %b want 1", bus.out_executed); else passed++;
    total++; if (bus.alu_out !== 32'd5) $display("FAIL subeq_result got %h want 5", bus.alu_out); else passed++;
    issue(OpCmp, CAl, 1'b0, 32'd5, 32'd5, 1'b0);
    issue(OpSub, CNe, 1'b1, 32'd9, 32'd4, 1'b0);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL subne_valid got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_executed !== 1'b0) $display("FAIL subne_exec got %b want 0", bus.out_executed); else passed++;
    total++; if (bus.alu_out !== 32'h0) $display("FAIL subne_result got %h want 0", bus.alu_out); else passed++;
    total++; if (bus.out_wr_en !== 1'b0) $display("FAIL subne_wr_en got %b want 0", bus.out_wr_en); else passed++;
    total++; if (flags_out !== 4'b0110) $display("FAIL subne_flags got %b want 0110", flags_out); else passed++;
  endtask

  task automatic test_carry_ops();
    load_flags(4'b0100);
    total++; if (flags_out !== 4'b0100) $display("FAIL flags_load got %b want 0100", flags_out); else passed++;
    issue(OpAdc, CAl, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    total++; if (bus.alu_out !== 32'h0) $display("FAIL adc_result got %h want 0", bus.alu_out); else passed++;
    total++; if (flags_out !== 4'b0110) $display("FAIL adc_flags got %b want 0110", flags_out); else passed++;
    load_flags(4'b0000);
    issue(OpSbc, CAl, 1'b0, 32'd3, 32'd1, 1'b0);
    total++; if (bus.alu_out !== 32'd1) $display("FAIL sbc_result got %h want 1", bus.alu_out); else passed++;
  endtask

  task automatic test_logical();
    load_flags(4'b1000);
    issue(OpMov, CAl, 1'b1, 32'h1234, 32'h0, 1'b1);
    total++; if (bus.alu_out !== 32'h0) $display("FAIL movs_result got %h want 0", bus.alu_out); else passed++;
    total++; if (flags_out !== 4'b1110) $display("FAIL movs_flags got %b want 1110", flags_out); else passed++;
  endtask

  task automatic test_flags_wr_priority();
    flags_wr_in = 1'b1;
    flags_in    = 4'b0001;
    issue(OpAdd, CAl, 1'b1, 32'd1, 32'd1, 1'b0);
    flags_wr_in = 1'b0;
    total++; if (flags_out !== 4'b0001) $display("FAIL wr_prio_flags got %b want 0001", flags_out); else passed++;
    total++; if (bus.alu_out !== 32'd2) $display("FAIL wr_prio_result got %h want 2", bus.alu_out); else passed++;
  endtask

  task automatic test_cond_codes();
    logic [3:0] tf [8];
    logic [3:0] tc [8];
    logic       te [8];
    tf[0] = 4'b0110; tc[0] = 4'b0000; te[0] = 1'b1;
    tf[1] = 4'b0110; tc[1] = 4'b0001; te[1] = 1'b0;
    tf[2] = 4'b0110; tc[2] = 4'b1000; te[2] = 1'b0;
    tf[3] = 4'b0110; tc[3] = 4'b1001; te[3] = 1'b1;
    tf[4] = 4'b1001; tc[4] = 4'b1010; te[4] = 1'b1;
    tf[5] = 4'b1001; tc[5] = 4'b1011; te[5] = 1'b0;
    tf[6] = 4'b1001; tc[6] = 4'b1100; te[6] = 1'b1;
    tf[7] = 4'b1001; tc[7] = 4'b1111; te[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load_flags(tf[i]);
      issue(OpAdd, tc[i], 1'b0, 32'd1, 32'd2, 1'b0);
      total++;
      if (bus.out_executed !== te[i] || bus.alu_out !== (te[i] ? 32'd3 : 32'd0))
        $display("FAIL cond_%0d exec/result got %b/%h want %b/%h", i, bus.out_executed,
                 bus.alu_out, te[i], te[i] ? 32'd3 : 32'd0);
      else passed++;
    end
  endtask

  task automatic test_stall();
    @(posedge clk);
    #1;
    bus.out_ready        = 1'b0;
    bus.in_valid         = 1'b1;
    bus.opcode_in        = OpAdd;
    bus.cond_in          = CAl;
    bus.s_in             = 1'b0;
    bus.a_in             = 32'd10;
    bus.b_in             = 32'd1;
    bus.shifter_carry_in = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus.alu_out !== 32'd11) $display("FAIL stall_first got %h want b", bus.alu_out); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", bus.in_ready); else passed++;
    bus.a_in = 32'd20;
    bus.b_in = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.alu_out !== 32'd11 || bus.in_ready !== 1'b0)
        $display("FAIL stall_hold_%0d got %h/%b want b/0", i, bus.alu_out, bus.in_ready);
      else passed++;
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", bus.in_ready); else passed++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.alu_out !== 32'd22)
      $display("FAIL release_next got %b/%h want 1/16", bus.out_valid, bus.alu_out); else passed++;
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", bus.out_valid); else passed++;
  endtask

`ifdef ALU_STICKY_Q_EN
  task automatic test_sticky_q();
    total++; if (q_flag_out !== 1'b0) $display("FAIL q_initial got %b want 0", q_flag_out); else passed++;
    issue(OpAdd, CAl, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0);
    total++; if (q_flag_out !== 1'b1) $display("FAIL q_set got %b want 1", q_flag_out); else passed++;
    issue(OpAdd, CAl, 1'b1, 32'd1, 32'd1, 1'b0);
    total++; if (q_flag_out !== 1'b1) $display("FAIL q_sticky got %b want 1", q_flag_out); else passed++;
    q_clear = 1'b1;
    @(posedge clk);
    #1;
    total++; if (q_flag_out !== 1'b0) $display("FAIL q_clear got %b want 0", q_flag_out); else passed++;
    issue(OpAdd, CAl, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0);
    q_clear = 1'b0;
    total++; if (q_flag_out !== 1'b1) $display("FAIL q_set_wins got %b want 1", q_flag_out); else passed++;
  endtask
`endif

  task automatic test_async_reset();
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    issue(OpAdd, CAl, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
    total++; if (bus.out_valid !== 1'b1 || flags_out !== 4'b0001)
      $display("FAIL pre_reset got %b/%b want 1/0001", bus.out_valid, flags_out); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL async_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (flags_out !== 4'b0000) $display("FAIL async_flags got %b want 0000", flags_out); else passed++;
    total++; if (bus.alu_out !== 32'h0) $display("FAIL async_alu_out got %h want 0", bus.alu_out); else passed++;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    passed               = 0;
    total                = 0;
    rst_n                = 1'b0;
    flags_wr_in          = 1'b0;
    flags_in             = 4'b0000;
    bus.in_valid         = 1'b0;
    bus.opcode_in        = 4'b0000;
    bus.cond_in          = CAl;
    bus.s_in             = 1'b0;
    bus.a_in             = '0;
    bus.b_in             = '0;
    bus.shifter_carry_in = 1'b0;
    bus.out_ready        = 1'b1;
`ifdef ALU_STICKY_Q_EN
    q_clear = 1'b0;
`endif
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_carry_ops();
    test_logical();
    test_flags_wr_priority();
    test_cond_codes();
    test_stall();
`ifdef ALU_STICKY_Q_EN
    test_sticky_q();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop in case a wait never returns.
  initial begin
    #100000;
    $display("FAIL timeout passed %0d of %0d before stop", passed, total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_cond_pipe.md
Name: alu_cond_pipe

Overview:
- Parametrised, registered successor to the combinational data-processing ALU.
- Executes all 16 addressing-mode-1 opcodes at width N and owns the architectural NZCV flag register.
- Evaluates the instruction condition field against that flag register, and returns results over a valid/ready handshake.
- Sits between the shifter/operand-fetch stage and the writeback stage of the execute pipeline.

Parameters:
N, 32, datapath width in bits (legal range 8..64).

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous reset, active-low.
in_valid  input  1  operation presented.
in_ready  output  1  block can accept an operation this cycle.
opcode_in  input  4  data-processing opcode, same encoding as the existing ALU (0000 AND … 1111 MVN).
cond_in  input  4  ARM condition field (0000 EQ … 1110 AL, 1111 NV).
s_in  input  1  S suffix; request flag update.
a_in  input  N  Rn operand.
b_in  input  N  shifter operand.
shifter_carry_in  input  1  shifter carry-out; becomes C for logical ops.
flags_wr_in  input  1  direct flag-register load (MSR path).
flags_in  input  4  value for direct load, {V,C,Z,N}.
out_valid  output  1  result register holds an operation.
out_ready  input  1  downstream accepts the result.
alu_out  output  N  result (Rd value).
out_executed  output  1  condition passed.
out_wr_en  output  1  Rd writeback required.
flags_out  output  4  current flag register: [3]=V, [2]=C, [1]=Z, [0]=N.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, alu_out=0, out_executed=0, out_wr_en=0.
  - flags register 0000.
  - Takes effect immediately and holds until rst_n is high at a clock edge; any in-flight result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Latency is 1 cycle: the result is visible in the cycle after acceptance.
  - Output holds stable while out_valid && !out_ready.
  - Back-to-back acceptance is allowed every cycle when out_ready=1.
  - out_valid clears only on a transfer with no new acceptance.
- Condition check:
  - Evaluated at acceptance against the flags register value before this op updates it.
  - Codes follow the standard ARM set: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV 0.
  - Because flags are registered on acceptance, an op accepted in the next cycle sees updated flags; no extra forwarding is needed.
- Failed condition:
  - Result still enters the output register with out_valid=1.
  - out_executed=0, out_wr_en=0, alu_out=0, flags unchanged.
- Arithmetic, computed in N+1 bits:
  - C = carry-out for ADD/ADC/CMN.
  - C = NOT borrow (a>=b unsigned, including carry term) for SUB/SBC/RSB/RSC/CMP.
  - ADC adds the flag-register C; SBC/RSC subtract !C, where C is the flag-register C (no external carry input).
  - V is signed overflow using the standard add/sub formulas.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = shifter_carry_in, V unchanged.
- All ops: N = result[N-1]; Z = (result==0).
- Flag update happens when executed && (s_in || opcode in 10xx).
- Compare ops (10xx, i.e. TST/TEQ/CMP/CMN):
  - Always update flags when executed, regardless of s_in.
  - out_wr_en=0; alu_out still carries the computed value.
- Executed non-compare ops: out_wr_en=1.
- flags_wr_in:
  - Loads flags_in at the next edge.
  - Wins over an ALU flag update in the same cycle.
  - Independent of the handshake.
- flags_out always reflects the register, not the pending result.

Optional Feature:
- Macro ALU_STICKY_Q_EN.
- When defined, adds:
  - Output q_flag_out (1 bit), reset 0. It is set by any executed arithmetic op whose V result is 1, whether or not flags are written.
  - Input q_clear (1 bit), which clears q_flag_out at the next edge; a set in the same cycle wins.
- When undefined: neither port exists and no Q state is built.

Test Plan:
- Reset, then ADD, cond AL, S=1, a=0x7FFFFFFF, b=1 -> next cycle out_valid=1, alu_out=0x80000000, flags_out V=1 C=0 Z=0 N=1 (1001), out_wr_en=1.
- CMP a=5 b=5 (s_in=0), then next cycle SUBEQ a=9 b=4 -> first: flags Z=1, C=1, out_wr_en=0; second: executed=1, alu_out=5. Repeat with second op NE -> out_executed=0, alu_out=0, flags unchanged.
- flags C=1 via flags_wr_in, then ADC S=1 a=0xFFFFFFFF b=0 -> alu_out=0, C=1, Z=1; then SBC a=3 b=1 with C=0 -> alu_out=1.
- MOVS b=0 with shifter_carry_in=1 and V preloaded to 1 -> alu_out=0, Z=1, C=1, V stays 1.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after first accept, alu_out stable; release -> next op accepted same cycle as transfer, no loss or duplication.
- Assert rst_n low mid-stall with out_valid=1 -> out_valid and flags go 0 immediately, without waiting for a clock edge; with ALU_STICKY_Q_EN, overflow ADD sets q_flag_out=1, which survives a later non-overflow op and clears only on q_clear.
